// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port 8-bit memory between the CPU (port 0)
// and a debug/loader DMA (port 1). Each access takes ACCESS then RESP, and a
// clear sweep zeroes the whole memory one word per cycle.
// Build option: define MEM_ARB_RR_EN to make simultaneous requests take
// turns (round-robin); without it port 0 always wins a tie.
module mem_arbiter #(
    parameter int DEPTH = 256,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [7:0]    wdata0,
    input  logic [7:0]    wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [7:0]    rdata0,
    output logic [7:0]    rdata1,
    input  logic          clr_req,
    output logic          busy,
    output logic          mem_ce,
    output logic          mem_w,
    output logic          mem_r,
    output logic          mem_oe,
    output logic          mem_rst,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;

    state_t          state_reg, state_next;
    logic            port_reg;
    logic            we_reg;
    logic [AW-1:0]   addr_reg;
    logic [7:0]      wdata_reg;
    logic [CW-1:0]   cnt_reg;
    logic [7:0]      rdata0_reg, rdata1_reg;
    logic            win;
    logic            any_req;
    logic            in_range;

    assign any_req  = req0 | req1;
    assign in_range = ({1'b0, addr_reg} < DEPTH_EXT);
    assign rdata0   = rdata0_reg;
    assign rdata1   = rdata1_reg;

`ifdef MEM_ARB_RR_EN
    logic last_reg;

    // Winner selection: on a tie the port not granted last goes first
    always_comb begin
        if (req0 && req1) win = ~last_reg;
        else              win = ~req0;
    end

    // Track which port most recently entered ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        last_reg <= 1'b1;
        else if (state_reg == IDLE && !clr_req && any_req) last_reg <= win;
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not requesting
    assign win = ~req0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic and memory/handshake strobes
    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        ack0       = 1'b0;
        ack1       = 1'b0;
        mem_ce     = 1'b0;
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        mem_oe     = 1'b0;
        mem_rst    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                if (clr_req)      state_next = CLEAR;
                else if (any_req) state_next = ACCESS;
            end
            ACCESS: begin
                mem_addr  = addr_reg;
                mem_wdata = wdata_reg;
                // Out-of-range addresses never touch the memory
                if (in_range) begin
                    mem_ce = 1'b1;
                    mem_w  = we_reg;
                    mem_r  = ~we_reg;
                    mem_oe = ~we_reg;
                end
                state_next = RESP;
            end
            RESP: begin
                ack0       = ~port_reg;
                ack1       = port_reg;
                state_next = IDLE;
            end
            CLEAR: begin
                mem_ce   = 1'b1;
                mem_rst  = 1'b1;
                mem_addr = AW'(cnt_reg);
                if (cnt_reg == LAST_IDX) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching, read-data capture and sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_reg   <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            cnt_reg    <= '0;
            rdata0_reg <= 8'h00;
            rdata1_reg <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clr_req) begin
                        cnt_reg <= '0;
                    end else if (any_req) begin
                        port_reg  <= win;
                        we_reg    <= win ? we1 : we0;
                        addr_reg  <= win ? addr1 : addr0;
                        wdata_reg <= win ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    if (!we_reg) begin
                        if (port_reg) rdata1_reg <= in_range ? mem_rdata : 8'h00;
                        else          rdata0_reg <= in_range ? mem_rdata : 8'h00;
                    end
                end
                CLEAR: begin
                    // Counter parks on the last word rather than wrapping
                    if (cnt_reg != LAST_IDX) cnt_reg <= cnt_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed transactions on both ports and the
// clear sweep, checked against a word-array reference memory and a
// transaction-level arbitration model. Honors MEM_ARB_RR_EN like the design.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [7:0]    wdata0, wdata1;
    logic          ack0, ack1;
    logic [7:0]    rdata0, rdata1;
    logic          clr_req, busy;
    logic          mem_ce, mem_w, mem_r, mem_oe, mem_rst;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;

    mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .clr_req(clr_req), .busy(busy),
        .mem_ce(mem_ce), .mem_w(mem_w), .mem_r(mem_r), .mem_oe(mem_oe),
        .mem_rst(mem_rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory driven only by the arbiter's strobes
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_ce && mem_w)        mem[mem_addr[7:0]] <= mem_wdata;
        else if (mem_ce && mem_rst) mem[mem_addr[7:0]] <= 8'h00;
    end
    assign mem_rdata = (mem_ce && mem_r && mem_oe) ? mem[mem_addr[7:0]] : 8'hEE;

    // Reference model state
    logic [7:0] ref_mem [0:255];
    int         model_last = 1;
    int         exp_w_cycles = 0;
    int         w_cycles = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Idle must be quiet: no acks, strobes, address or data
    always @(negedge clk) begin
        if (!rst && !busy)
            chk("idle_quiet", {ack0, ack1, mem_ce, mem_w, mem_r, mem_oe, mem_rst, mem_addr, mem_wdata}, 64'h0);
        if (mem_w) w_cycles++;
    end

    logic          op_we   [0:1][0:3];
    logic [15:0]   op_addr [0:1][0:3];
    logic [7:0]    op_wd   [0:1][0:3];

    task automatic set_op(input int p, input int i, input logic w, input logic [15:0] a, input logic [7:0] d);
        op_we[p][i] = w; op_addr[p][i] = a; op_wd[p][i] = d;
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Apply one completed access to the reference memory; return expected read data
    task automatic model_access(input logic w, input logic [15:0] a, input logic [7:0] d, output logic [7:0] rd);
        rd = 8'h00;
        if (a < 16'(DEPTH)) begin
            if (w) begin ref_mem[a[7:0]] = d; exp_w_cycles++; end
            else   rd = ref_mem[a[7:0]];
        end
    endtask

    // Run n0 ops on port 0 and n1 on port 1, both starting together; each
    // requester re-raises immediately after its ack if it has more work.
    task automatic run_ops(input int n0, input int n1, input string tag);
        int ord[$];
        int n[2];
        int idx[2];
        bit rearm[2];
        int r0, r1, last, w, k, done, cyc, last_ack, p, i;
        logic [4:0]  pv_strb, exp_strb;
        logic [15:0] pv_addr;
        logic [7:0]  pv_wd, exp_rd, got_rd;
        n[0] = n0; n[1] = n1;
        r0 = n0; r1 = n1; last = model_last;
        while (r0 + r1 > 0) begin
            if (r0 > 0 && r1 > 0) w = RR ? (last == 0 ? 1 : 0) : 0;
            else                  w = (r0 > 0) ? 0 : 1;
            ord.push_back(w);
            last = w;
            if (w == 0) r0--; else r1--;
        end
        idx[0] = 0; idx[1] = 0; rearm[0] = 0; rearm[1] = 0;
        for (int q = 0; q < 2; q++)
            if (n[q] > 0) drive(q, 1'b1, op_we[q][0], op_addr[q][0], op_wd[q][0]);
        k = 0; done = 0; cyc = 0; last_ack = 0;
        pv_strb = '0; pv_addr = '0; pv_wd = '0;
        while (done < n0 + n1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            for (int q = 0; q < 2; q++) begin
                if (rearm[q] && idx[q] < n[q])
                    drive(q, 1'b1, op_we[q][idx[q]], op_addr[q][idx[q]], op_wd[q][idx[q]]);
                rearm[q] = 0;
            end
            if (ack0 || ack1) begin
                chk("one_ack", {ack0, ack1} == 2'b11, 0);
                p = (ack1 && !ack0) ? 1 : 0;
                chk("grant_order", p, (k < ord.size()) ? ord[k] : 9);
                if (idx[p] >= n[p]) begin
                    chk("spurious_ack", p, 9);
                end else begin
                    i = idx[p];
                    if (k == 0) chk("latency", cyc, 2);
                    else        chk("ack_gap", cyc - last_ack, 3);
                    exp_strb = (op_addr[p][i] < 16'(DEPTH)) ?
                               {1'b1, op_we[p][i], !op_we[p][i], !op_we[p][i], 1'b0} : 5'b0;
                    chk("acc_strb", pv_strb, exp_strb);
                    chk("acc_addr", pv_addr, op_addr[p][i]);
                    chk("acc_wdata", pv_wd, op_wd[p][i]);
                    chk("resp_quiet", {busy, mem_ce, mem_w, mem_r, mem_oe, mem_rst, mem_addr, mem_wdata},
                        {1'b1, 29'h0});
                    model_access(op_we[p][i], op_addr[p][i], op_wd[p][i], exp_rd);
                    if (!op_we[p][i]) begin
                        got_rd = p ? rdata1 : rdata0;
                        chk("rdata", got_rd, exp_rd);
                    end
                    $display("txn %s port=%0d we=%0d addr=%04h wdata=%02h rdata=%02h cyc=%0d",
                             tag, p, op_we[p][i], op_addr[p][i], op_wd[p][i], p ? rdata1 : rdata0, cyc);
                    model_last = p;
                    idx[p]++; done++; k++; last_ack = cyc;
                    drive(p, 1'b0, 1'b0, 16'h0, 8'h0);
                    rearm[p] = 1;
                end
            end
            pv_strb = {mem_ce, mem_w, mem_r, mem_oe, mem_rst};
            pv_addr = mem_addr;
            pv_wd   = mem_wdata;
        end
        if (done < n0 + n1) chk("run_timeout", done, n0 + n1);
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
    endtask

    // Clear sweep, optionally with a port-0 request raised at the same time
    task automatic do_clear(input logic with_req, input logic w, input logic [15:0] a, input logic [7:0] d);
        int i;
        logic [7:0] exp_rd;
        logic [4:0] exp_strb;
        clr_req = 1'b1;
        if (with_req) drive(0, 1'b1, w, a, d);
        @(negedge clk);
        clr_req = 1'b0;
        i = 0;
        while (busy && i < 400) begin
            chk("clr_step", {mem_ce, mem_rst, mem_w, mem_r, mem_oe, ack0, ack1, mem_addr},
                {5'b11000, 2'b00, 16'(i)});
            i++;
            @(negedge clk);
        end
        chk("clr_len", i, DEPTH);
        for (int j = 0; j < 256; j++) ref_mem[j] = 8'h00;
        $display("txn clear with_req=%0d busy_cycles=%0d", with_req, i);
        if (with_req) begin
            @(negedge clk);
            exp_strb = (a < 16'(DEPTH)) ? {1'b1, w, !w, !w, 1'b0} : 5'b0;
            chk("clr_acc_strb", {mem_ce, mem_w, mem_r, mem_oe, mem_rst}, exp_strb);
            chk("clr_acc_addr", mem_addr, a);
            @(negedge clk);
            chk("clr_ack", {ack0, ack1}, 2'b10);
            model_access(w, a, d, exp_rd);
            if (!w) chk("clr_rdata", rdata0, exp_rd);
            model_last = 0;
            drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
            @(negedge clk);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 16'($urandom_range(0, 255));
        else if (r == 7) return ($urandom_range(0, 1) == 0) ? 16'd255 : 16'd256;
        else             return 16'($urandom_range(256, 65535));
    endfunction

    initial begin
        int n0, n1;
        rst = 1'b1; clr_req = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        #3;
        chk("reset_out", {busy, ack0, ack1, mem_ce, mem_w, mem_r, mem_oe, mem_rst, mem_addr, mem_wdata, rdata0, rdata1}, 64'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clear with a pending read of the last word
        do_clear(1'b1, 1'b0, 16'h00FF, 8'h00);

        // Read of a preloaded word
        set_op(1, 0, 1'b1, 16'h0010, 8'hA5); run_ops(0, 1, "preload");
        set_op(0, 0, 1'b0, 16'h0010, 8'h00); run_ops(1, 0, "read");

        // Write from port 1 then read back on port 0
        set_op(1, 0, 1'b1, 16'h0020, 8'h3C); run_ops(0, 1, "write");
        set_op(0, 0, 1'b0, 16'h0020, 8'h00); run_ops(1, 0, "readback");

        // Simultaneous requests
        repeat (4) begin
            set_op(0, 0, 1'b0, 16'h0010, 8'h00);
            set_op(1, 0, 1'b0, 16'h0020, 8'h00);
            run_ops(1, 1, "tie");
        end
        set_op(0, 0, 1'b1, 16'h0040, 8'h11);
        set_op(0, 1, 1'b1, 16'h0041, 8'h22);
        set_op(1, 0, 1'b1, 16'h0042, 8'h33);
        run_ops(2, 1, "tie_busy0");

        // Out-of-range read and write
        set_op(0, 0, 1'b0, 16'h0100, 8'h00); run_ops(1, 0, "oor_read");
        set_op(1, 0, 1'b1, 16'h0100, 8'h5A); run_ops(0, 1, "oor_write");

        // Reset in the middle of a write
        set_op(0, 0, 1'b1, 16'h0030, 8'h77); run_ops(1, 0, "pre30");
        set_op(0, 0, 1'b0, 16'h0010, 8'h00);
        set_op(1, 0, 1'b0, 16'h0020, 8'h00);
        run_ops(1, 1, "pre_rst");
        drive(0, 1'b1, 1'b1, 16'h0030, 8'h99);
        @(negedge clk);
        chk("rst_mid_w", mem_w, 1'b1);
        exp_w_cycles++;
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {busy, ack0, ack1, mem_ce, mem_w, mem_r, mem_oe, mem_rst, mem_addr, mem_wdata, rdata0, rdata1}, 64'h0);
        @(posedge clk);
        #1;
        chk("rst_hold", {busy, ack0, ack1, mem_ce, mem_w, mem_rst}, 6'h0);
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        @(negedge clk);
        chk("rst_keep30", mem[8'h30], 8'h77);
        $display("txn reset_mid_write addr=0030");

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_clear(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            end else begin
                n0 = $urandom_range(0, 2);
                n1 = $urandom_range((n0 == 0) ? 1 : 0, 2);
                for (int q = 0; q < 2; q++)
                    for (int j = 0; j < 2; j++)
                        set_op(q, j, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
                run_ops(n0, n1, "rand");
            end
        end

        for (int a = 0; a < 256; a++) chk("mem_final", mem[a], ref_mem[a]);
        chk("w_cycles", w_cycles, exp_w_cycles);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
